rf_wb_arb: RTL and testbench

Register-file write-port arbiter and load scoreboard for the decode/writeback stage. The RF has a single write port. This block shares it between two sources:
- the in-order core writeback path (wd_sel mux result);
- late load data returned by a multi-cycle DRAM/LSU path, buffered in a small FIFO.

It also tracks registers with outstanding loads and raises a read hazard so decode stalls until the load data has been committed.

---
 rtl/rf_wb_arb_if.sv | 42 ++++
 rtl/rf_wb_arb.sv | 230 +++++++++++++++++++++++
 tb/tb_rf_wb_arb.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arb_if.sv
// Bus bundle between the decode/writeback pipeline and the RF write-port arbiter.
// The master side is the pipeline; the slave side is rf_wb_arb.
interface rf_wb_arb_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          core_we;
    logic [4:0]    core_wr;
    logic [31:0]   core_wd;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_wr;
    logic [31:0]   lsu_wd;
    logic          pend_set;
    logic [4:0]    pend_rd;
    logic [4:0]    rR1;
    logic [4:0]    rR2;
    logic          hazard;
    logic          hold_pipe;
    logic          rf_we;
    logic [4:0]    rf_wr;
    logic [31:0]   rf_wd;
    logic [CW-1:0] fifo_cnt;
    logic          waw_err;

    modport master (
        output core_we, core_wr, core_wd,
        output lsu_valid, lsu_wr, lsu_wd,
        output pend_set, pend_rd, rR1, rR2,
        input  lsu_ready, hazard, hold_pipe,
        input  rf_we, rf_wr, rf_wd, fifo_cnt, waw_err
    );

    modport slave (
        input  core_we, core_wr, core_wd,
        input  lsu_valid, lsu_wr, lsu_wd,
        input  pend_set, pend_rd, rR1, rR2,
        output lsu_ready, hazard, hold_pipe,
        output rf_we, rf_wr, rf_wd, fifo_cnt, waw_err
    );
endinterface

// File: rtl/rf_wb_arb.sv
// RF write-port arbiter: shares the single write port between core writeback and a
// late-load FIFO, with starvation relief and a pending-load scoreboard for decode.
module rf_wb_arb #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    rf_wb_arb_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef struct packed {
        logic [4:0]  wr;
        logic [31:0] wd;
    } entry_t;

    entry_t        mem_q [FIFO_DEPTH];
    entry_t        mem_d [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          hold_q, hold_d;
    logic          rf_we_q, rf_we_d;
    logic          rf_lsu_q, rf_lsu_d;
    logic [4:0]    rf_wr_q, rf_wr_d;
    logic [31:0]   rf_wd_q, rf_wd_d;
    logic [31:0]   pend_q, pend_d;
    logic          waw_q, waw_d;

    logic          core_ok_s;
    logic          fifo_ne_s;
    logic          lsu_ready_s;
    logic          push_s;
    logic          store_s;
    logic          pop_s;
    logic          core_win_s;
    logic          hazard_s;
    entry_t        head_s;

    // Request qualification and write-port arbitration for this cycle.
    always_comb begin
        core_ok_s   = bus.core_we && (bus.core_wr != 5'd0);
        fifo_ne_s   = (cnt_q != {CW{1'b0}});
        lsu_ready_s = (cnt_q != FULL_CNT);
        push_s      = bus.lsu_valid && lsu_ready_s;
        // x0 loads are accepted to keep the LSU flowing but never stored.
        store_s     = push_s && (bus.lsu_wr != 5'd0);
        head_s      = mem_q[rp_q];
        pop_s       = 1'b0;
        core_win_s  = 1'b0;
        if (hold_q && fifo_ne_s) begin
            pop_s = 1'b1;
        end else if (core_ok_s) begin
            core_win_s = 1'b1;
        end else if (fifo_ne_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s      = 1'b0;
            core_win_s = 1'b0;
        end
    end

    // Next registered write-port value; address/data hold when the port idles.
    always_comb begin
        rf_we_d  = 1'b0;
        rf_lsu_d = 1'b0;
        rf_wr_d  = rf_wr_q;
        rf_wd_d  = rf_wd_q;
        if (pop_s) begin
            rf_we_d  = 1'b1;
            rf_lsu_d = 1'b1;
            rf_wr_d  = head_s.wr;
            rf_wd_d  = head_s.wd;
        end else if (core_win_s) begin
            rf_we_d  = 1'b1;
            rf_lsu_d = 1'b0;
            rf_wr_d  = bus.core_wr;
            rf_wd_d  = bus.core_wd;
        end else begin
            rf_we_d  = 1'b0;
            rf_lsu_d = 1'b0;
        end
    end

    // Circular buffer storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (store_s) begin
            mem_d[wp_q] = '{wr: bus.lsu_wr, wd: bus.lsu_wd};
            wp_d        = wp_q + AW'(1'b1);
        end else begin
            wp_d = wp_q;
        end
        if (pop_s) begin
            rp_d = rp_q + AW'(1'b1);
        end else begin
            rp_d = rp_q;
        end
        case ({store_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1'b1);
            2'b01:   cnt_d = cnt_q - CW'(1'b1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Starvation counter: counts lost arbitrations of a non-empty FIFO.
    always_comb begin
        starve_d = starve_q;
        hold_d   = 1'b0;
        if (pop_s || !fifo_ne_s) begin
            starve_d = {SW{1'b0}};
        end else if (core_win_s) begin
            if ((starve_q + SW'(1'b1)) == STARVE_LIM) begin
                hold_d   = 1'b1;
                starve_d = {SW{1'b0}};
            end else begin
                starve_d = starve_q + SW'(1'b1);
            end
        end else begin
            starve_d = starve_q;
        end
    end

    // Scoreboard: a new load mark beats a same-cycle commit of that register.
    always_comb begin
        pend_d = pend_q;
        if (rf_we_q && rf_lsu_q) begin
            pend_d[rf_wr_q] = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (bus.pend_set && (bus.pend_rd != 5'd0)) begin
            pend_d[bus.pend_rd] = 1'b1;
        end else begin
            pend_d[0] = 1'b0;
        end
        pend_d[0] = 1'b0;
        waw_d     = waw_q || (core_ok_s && pend_q[bus.core_wr]);
        hazard_s  = ((bus.rR1 != 5'd0) && pend_q[bus.rR1]) ||
                    ((bus.rR2 != 5'd0) && pend_q[bus.rR2]);
    end

    // State update; reset discards queued loads and pending marks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q     <= {AW{1'b0}};
            rp_q     <= {AW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            starve_q <= {SW{1'b0}};
            hold_q   <= 1'b0;
            rf_we_q  <= 1'b0;
            rf_lsu_q <= 1'b0;
            rf_wr_q  <= 5'd0;
            rf_wd_q  <= 32'd0;
            pend_q   <= 32'd0;
            waw_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
            rf_we_q  <= rf_we_d;
            rf_lsu_q <= rf_lsu_d;
            rf_wr_q  <= rf_wr_d;
            rf_wd_q  <= rf_wd_d;
            pend_q   <= pend_d;
            waw_q    <= waw_d;
        end
    end

    assign bus.lsu_ready = lsu_ready_s;
    assign bus.hazard    = hazard_s;
    assign bus.hold_pipe = hold_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_wr     = rf_wr_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.fifo_cnt  = cnt_q;
    assign bus.waw_err   = waw_q;

    rf_wb_arb_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .lsu_ready (lsu_ready_s),
        .hold_pipe (hold_q),
        .waw_err   (waw_q),
        .fifo_cnt  (cnt_q),
        .pend      (pend_q)
    );
endmodule

// Structural invariants of the arbiter state.
module rf_wb_arb_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          lsu_ready,
    input logic          hold_pipe,
    input logic          waw_err,
    input logic [CW-1:0] fifo_cnt,
    input logic [31:0]   pend
);
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        fifo_cnt <= CW'(FIFO_DEPTH));
    a_ready_full: assert property (@(posedge clk) disable iff (rst)
        lsu_ready == (fifo_cnt != CW'(FIFO_DEPTH)));
    a_hold_pulse: assert property (@(posedge clk) disable iff (rst)
        hold_pipe |=> !hold_pipe);
    a_waw_sticky: assert property (@(posedge clk) disable iff (rst)
        waw_err |=> waw_err);
    a_x0_clear: assert property (@(posedge clk) disable iff (rst)
        !pend[0]);
endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_rf_wb_arb;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    rf_wb_arb_if #(.FIFO_DEPTH(DEPTH)) bus ();

    rf_wb_arb #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: the FIFO is a queue of {wr, wd}.
    logic [36:0] m_q [$];
    logic [31:0] m_pend = 32'd0;
    logic        m_we   = 1'b0;
    logic        m_lsu  = 1'b0;
    logic        m_hold = 1'b0;
    logic        m_waw  = 1'b0;
    logic [4:0]  m_wr   = 5'd0;
    logic [31:0] m_wd   = 32'd0;
    int          m_lost = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = 32'd0;
        m_we   = 1'b0;
        m_lsu  = 1'b0;
        m_hold = 1'b0;
        m_waw  = 1'b0;
        m_wr   = 5'd0;
        m_wd   = 32'd0;
        m_lost = 0;
    endtask

    task automatic model_step();
        logic        core_ok;
        logic        ne;
        logic        push;
        logic        take;
        logic [36:0] e;
        logic [31:0] np;
        core_ok = bus.core_we && (bus.core_wr != 5'd0);
        ne      = (m_q.size() > 0);
        push    = bus.lsu_valid && (m_q.size() < DEPTH);
        take    = ne && (m_hold || !core_ok);
        np = m_pend;
        if (m_we && m_lsu) np[m_wr] = 1'b0;
        if (bus.pend_set && (bus.pend_rd != 5'd0)) np[bus.pend_rd] = 1'b1;
        if (core_ok && m_pend[bus.core_wr]) m_waw = 1'b1;
        m_pend = np;
        if (take) begin
            e     = m_q.pop_front();
            m_we  = 1'b1;
            m_lsu = 1'b1;
            m_wr  = e[36:32];
            m_wd  = e[31:0];
        end else if (core_ok) begin
            m_we  = 1'b1;
            m_lsu = 1'b0;
            m_wr  = bus.core_wr;
            m_wd  = bus.core_wd;
        end else begin
            m_we  = 1'b0;
            m_lsu = 1'b0;
        end
        if (take || !ne) m_lost = 0;
        else if (core_ok) m_lost++;
        m_hold = 1'b0;
        if (m_lost == SMAX) begin
            m_hold = 1'b1;
            m_lost = 0;
        end
        if (push && (bus.lsu_wr != 5'd0)) m_q.push_back({bus.lsu_wr, bus.lsu_wd});
    endtask

    // Model advances on every clock edge and on asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        logic exp_hz;
        forever begin
            @(negedge clk);
            exp_hz = ((bus.rR1 != 5'd0) && m_pend[bus.rR1]) ||
                     ((bus.rR2 != 5'd0) && m_pend[bus.rR2]);
            chk("model.rf_we", 32'(bus.rf_we), 32'(m_we));
            if (m_we || rst) begin
                chk("model.rf_wr", 32'(bus.rf_wr), 32'(m_wr));
                chk("model.rf_wd", bus.rf_wd, m_wd);
            end
            chk("model.hold_pipe", 32'(bus.hold_pipe), 32'(m_hold));
            chk("model.fifo_cnt", 32'(bus.fifo_cnt), 32'(m_q.size()));
            chk("model.lsu_ready", 32'(bus.lsu_ready), 32'(m_q.size() < DEPTH));
            chk("model.hazard", 32'(bus.hazard), 32'(exp_hz));
            chk("model.waw_err", 32'(bus.waw_err), 32'(m_waw));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.core_we   = 1'b0;
        bus.core_wr   = 5'd0;
        bus.core_wd   = 32'd0;
        bus.lsu_valid = 1'b0;
        bus.lsu_wr    = 5'd0;
        bus.lsu_wd    = 32'd0;
        bus.pend_set  = 1'b0;
        bus.pend_rd   = 5'd0;
        bus.rR1       = 5'd0;
        bus.rR2       = 5'd0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'd0);
        chk({tag, ".rf_wr"}, 32'(bus.rf_wr), 32'd0);
        chk({tag, ".rf_wd"}, bus.rf_wd, 32'd0);
        chk({tag, ".hold_pipe"}, 32'(bus.hold_pipe), 32'd0);
        chk({tag, ".waw_err"}, 32'(bus.waw_err), 32'd0);
        chk({tag, ".fifo_cnt"}, 32'(bus.fifo_cnt), 32'd0);
        chk({tag, ".lsu_ready"}, 32'(bus.lsu_ready), 32'd1);
        chk({tag, ".hazard"}, 32'(bus.hazard), 32'd0);
    endtask

    initial begin
        int i;
        idle();
        #1 rst = 1'b1;
        #1 chk_reset_vals("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // Core-only writes, including x0.
        bus.core_we = 1'b1; bus.core_wr = 5'd5; bus.core_wd = 32'h1234;
        tick();
        idle();
        chk("core.rf_we", 32'(bus.rf_we), 32'd1);
        chk("core.rf_wr", 32'(bus.rf_wr), 32'd5);
        chk("core.rf_wd", bus.rf_wd, 32'h1234);
        bus.core_we = 1'b1; bus.core_wr = 5'd0; bus.core_wd = 32'h9999;
        tick();
        idle();
        chk("core_x0.rf_we", 32'(bus.rf_we), 32'd0);

        // Load path with hazard on r7.
        bus.pend_set = 1'b1; bus.pend_rd = 5'd7; bus.rR1 = 5'd7;
        tick();
        bus.pend_set = 1'b0;
        chk("load.hazard_set", 32'(bus.hazard), 32'd1);
        bus.lsu_valid = 1'b1; bus.lsu_wr = 5'd7; bus.lsu_wd = 32'hCAFE;
        tick();
        bus.lsu_valid = 1'b0;
        chk("load.cnt_push", 32'(bus.fifo_cnt), 32'd1);
        chk("load.hazard_wait", 32'(bus.hazard), 32'd1);
        tick();
        chk("load.rf_we", 32'(bus.rf_we), 32'd1);
        chk("load.rf_wr", 32'(bus.rf_wr), 32'd7);
        chk("load.rf_wd", bus.rf_wd, 32'hCAFE);
        chk("load.hazard_commit", 32'(bus.hazard), 32'd1);
        tick();
        chk("load.hazard_drop", 32'(bus.hazard), 32'd0);
        chk("load.waw_err", 32'(bus.waw_err), 32'd0);
        idle();

        // Fill the FIFO under constant core traffic, then drain in order.
        for (i = 0; i < 4; i++) begin
            bus.core_we = 1'b1; bus.core_wr = 5'd1; bus.core_wd = 32'(i);
            bus.lsu_valid = 1'b1; bus.lsu_wr = 5'(8 + i); bus.lsu_wd = 32'(32'hA0 + i);
            tick();
        end
        chk("fill.cnt_full", 32'(bus.fifo_cnt), 32'd4);
        chk("fill.ready_low", 32'(bus.lsu_ready), 32'd0);
        bus.lsu_wr = 5'd13; bus.lsu_wd = 32'hDEAD;
        tick();
        chk("fill.cnt_reject", 32'(bus.fifo_cnt), 32'd4);
        chk("fill.core_won", 32'(bus.rf_wr), 32'd1);
        idle();
        for (i = 0; i < 4; i++) begin
            tick();
            chk("drain.rf_we", 32'(bus.rf_we), 32'd1);
            chk("drain.rf_wr", 32'(bus.rf_wr), 32'(8 + i));
            chk("drain.rf_wd", bus.rf_wd, 32'(32'hA0 + i));
            chk("drain.cnt", 32'(bus.fifo_cnt), 32'(3 - i));
        end

        // Starvation: one queued entry against a core writing every cycle.
        bus.core_we = 1'b1; bus.core_wr = 5'd1; bus.core_wd = 32'h55;
        bus.lsu_valid = 1'b1; bus.lsu_wr = 5'd12; bus.lsu_wd = 32'hBEEF;
        tick();
        bus.lsu_valid = 1'b0;
        i = 0;
        while (!bus.hold_pipe && (i < 20)) begin
            tick();
            i++;
        end
        bus.core_we = 1'b0;
        chk("starve.lost_cycles", 32'(i), 32'd8);
        chk("starve.hold_high", 32'(bus.hold_pipe), 32'd1);
        tick();
        chk("starve.hold_pulse", 32'(bus.hold_pipe), 32'd0);
        chk("starve.rf_we", 32'(bus.rf_we), 32'd1);
        chk("starve.rf_wr", 32'(bus.rf_wr), 32'd12);
        chk("starve.rf_wd", bus.rf_wd, 32'hBEEF);
        idle();

        // Set and commit of r3 in the same cycle, then a WAW on r3.
        bus.pend_set = 1'b1; bus.pend_rd = 5'd3;
        tick();
        bus.pend_set = 1'b0;
        bus.lsu_valid = 1'b1; bus.lsu_wr = 5'd3; bus.lsu_wd = 32'h33;
        tick();
        bus.lsu_valid = 1'b0;
        tick();
        chk("simul.rf_wr", 32'(bus.rf_wr), 32'd3);
        bus.pend_set = 1'b1; bus.pend_rd = 5'd3; bus.rR1 = 5'd3;
        tick();
        bus.pend_set = 1'b0;
        chk("simul.pend_kept", 32'(bus.hazard), 32'd1);
        bus.core_we = 1'b1; bus.core_wr = 5'd3; bus.core_wd = 32'h77;
        tick();
        bus.core_we = 1'b0;
        chk("waw.set", 32'(bus.waw_err), 32'd1);
        tick(); tick(); tick();
        chk("waw.sticky", 32'(bus.waw_err), 32'd1);
        idle();

        // Asynchronous reset with queued entries and pending marks.
        bus.pend_set = 1'b1; bus.pend_rd = 5'd9;
        for (i = 0; i < 3; i++) begin
            bus.core_we = 1'b1; bus.core_wr = 5'd1; bus.core_wd = 32'(i);
            bus.lsu_valid = 1'b1; bus.lsu_wr = 5'(20 + i); bus.lsu_wd = 32'(32'h700 + i);
            tick();
            bus.pend_set = 1'b0;
        end
        bus.lsu_valid = 1'b0; bus.rR1 = 5'd9;
        #1;
        chk("areset.cnt_before", 32'(bus.fifo_cnt), 32'd3);
        chk("areset.hazard_before", 32'(bus.hazard), 32'd1);
        rst = 1'b1;
        #1 chk_reset_vals("areset");
        idle();
        @(posedge clk);
        #2 rst = 1'b0;

        // Randomized traffic with bursts of heavy core activity and rare resets.
        for (int c = 0; c < 3000; c++) begin
            int busy;
            busy = (((c / 50) % 3) == 0) ? 95 : 45;
            bus.core_we   = !m_hold && ($urandom_range(0, 99) < busy);
            bus.core_wr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.core_wd   = $urandom;
            bus.lsu_valid = ($urandom_range(0, 99) < 40);
            bus.lsu_wr    = 5'($urandom_range(0, 15));
            bus.lsu_wd    = $urandom;
            bus.pend_set  = ($urandom_range(0, 99) < 20);
            bus.pend_rd   = 5'($urandom_range(0, 15));
            bus.rR1       = 5'($urandom_range(0, 15));
            bus.rR2       = 5'($urandom_range(0, 31));
            tick();
            if ($urandom_range(0, 399) == 0) begin
                #1 rst = 1'b1;
                @(posedge clk);
                #2 rst = 1'b0;
            end
        end
        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
